// File: rtl/dsp_post_adder_pkg.sv
// dsp_pkg: shared widths, OPMODE field codes and carry-select names for the DSP48A1 post-adder
package dsp_pkg;
  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam logic [1:0] X_ZERO = 2'b00, X_M = 2'b01, X_P = 2'b10, X_DAB = 2'b11;
  localparam logic [1:0] Z_ZERO = 2'b00, Z_PCIN = 2'b01, Z_P = 2'b10, Z_C = 2'b11;
  localparam logic OP_ADD = 1'b0, OP_SUB = 1'b1;
  localparam string CARRYSEL_OPMODE5 = "OPMODE5";
  localparam string CARRYSEL_CARRYIN = "CARRYIN";
endpackage

// File: rtl/dsp_post_adder_if.sv
// dsp_post_adder_if: operand/control/result bundle of the post-adder; ovf exists only with POSTADD_OVF_EN
interface dsp_post_adder_if;
  import dsp_pkg::*;
  logic [7:0]     opmode;
  logic [M_W-1:0] m;
  logic [P_W-1:0] dab, c, pcin;
  logic           carryin, cep, cecarryin;
  logic [P_W-1:0] p, pcout;
  logic           carryout, carryoutf;
`ifdef POSTADD_OVF_EN
  logic           ovf;
  modport master(output opmode, m, dab, c, pcin, carryin, cep, cecarryin,
                 input p, pcout, carryout, carryoutf, ovf);
  modport slave(input opmode, m, dab, c, pcin, carryin, cep, cecarryin,
                output p, pcout, carryout, carryoutf, ovf);
`else
  modport master(output opmode, m, dab, c, pcin, carryin, cep, cecarryin,
                 input p, pcout, carryout, carryoutf);
  modport slave(input opmode, m, dab, c, pcin, carryin, cep, cecarryin,
                output p, pcout, carryout, carryoutf);
`endif
endinterface

// File: rtl/dsp_post_adder_pipe_reg.sv
// dsp_pipe_reg: optional pipeline register (reset > CE hold > load); REG=0 passes d_i straight through
//   clk_i, rst_i (sync active-high), ce_i, d_i[W] -> q_o[W]
module dsp_pipe_reg #(
  parameter int W   = 1,
  parameter bit REG = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk_i)
    if (rst_i) q_q <= '0;
    else if (ce_i) q_q <= d_i;
  assign q_o = REG ? q_q : d_i;
endmodule

// File: rtl/dsp_post_adder.sv
// dsp_post_adder: DSP48A1 post-adder/accumulator, P = Z +/- (X + CIN) with carry; OVF only with POSTADD_OVF_EN
//   clk_i; rstp_i resets P/CARRYOUT/OVF; rstcarryin_i resets CYI; bus (slave) carries operands and results
module dsp_post_adder
  import dsp_pkg::*;
#(
  parameter bit    PREG       = 1'b1,
  parameter bit    CARRYINREG = 1'b1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input logic              clk_i,
  input logic              rstp_i,
  input logic              rstcarryin_i,
  dsp_post_adder_if.slave  bus
);
  logic           cyi_d, cin;
  logic [P_W-1:0] x, z;
  logic [P_W:0]   r, x_cin;
  logic           sub;
  assign sub   = bus.opmode[7] == OP_SUB;
  assign cyi_d = (CARRYINSEL == CARRYSEL_OPMODE5) ? bus.opmode[5] : bus.carryin;
  dsp_pipe_reg #(.W(1), .REG(CARRYINREG)) u_cyi (
    .clk_i(clk_i), .rst_i(rstcarryin_i), .ce_i(bus.cecarryin), .d_i(cyi_d), .q_o(cin)
  );
  assign x = bus.opmode[1:0] == X_M   ? {{(P_W-M_W){1'b0}}, bus.m} :
             bus.opmode[1:0] == X_P   ? bus.p :
             bus.opmode[1:0] == X_DAB ? bus.dab : '0;
  assign z = bus.opmode[3:2] == Z_PCIN ? bus.pcin :
             bus.opmode[3:2] == Z_P    ? bus.p :
             bus.opmode[3:2] == Z_C    ? bus.c : '0;
  assign x_cin = {1'b0, x} + {{P_W{1'b0}}, cin};
  assign r     = sub ? {1'b0, z} - x_cin : {1'b0, z} + x_cin;
`ifdef POSTADD_OVF_EN
  // two guard bits hold the exact signed result; overflow when they disagree with bit 47
  logic [P_W+1:0] xs_cin, rs;
  logic           ovf_d;
  logic [P_W+1:0] bq;
  assign xs_cin = {{2{x[P_W-1]}}, x} + {{(P_W+1){1'b0}}, cin};
  assign rs     = sub ? {{2{z[P_W-1]}}, z} - xs_cin : {{2{z[P_W-1]}}, z} + xs_cin;
  assign ovf_d  = rs[P_W+1:P_W-1] != 3'b000 && rs[P_W+1:P_W-1] != 3'b111;
  dsp_pipe_reg #(.W(P_W+2), .REG(PREG)) u_p (
    .clk_i(clk_i), .rst_i(rstp_i), .ce_i(bus.cep), .d_i({ovf_d, r}), .q_o(bq)
  );
  assign {bus.ovf, bus.carryout, bus.p} = bq;
`else
  logic [P_W:0] bq;
  dsp_pipe_reg #(.W(P_W+1), .REG(PREG)) u_p (
    .clk_i(clk_i), .rst_i(rstp_i), .ce_i(bus.cep), .d_i(r), .q_o(bq)
  );
  assign {bus.carryout, bus.p} = bq;
`endif
  assign bus.pcout     = bus.p;
  assign bus.carryoutf = bus.carryout;
endmodule

// File: tb/tb_dsp_post_adder.sv
// tb_dsp_post_adder: directed vector table plus carry-latency and combinational sequences for dsp_post_adder
module tb_dsp_post_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstp_a, rstcy_a, rstp_b, rstcy_b, rstp_c, rstcy_c;
  dsp_post_adder_if ia();
  dsp_post_adder_if ib();
  dsp_post_adder_if ic();
  dsp_post_adder #(.PREG(1'b1), .CARRYINREG(1'b0), .CARRYINSEL("OPMODE5")) u_a (
    .clk_i(clk), .rstp_i(rstp_a), .rstcarryin_i(rstcy_a), .bus(ia));
  dsp_post_adder #(.PREG(1'b1), .CARRYINREG(1'b1), .CARRYINSEL("OPMODE5")) u_b (
    .clk_i(clk), .rstp_i(rstp_b), .rstcarryin_i(rstcy_b), .bus(ib));
  dsp_post_adder #(.PREG(1'b0), .CARRYINREG(1'b0), .CARRYINSEL("CARRYIN")) u_c (
    .clk_i(clk), .rstp_i(rstp_c), .rstcarryin_i(rstcy_c), .bus(ic));
  typedef struct {
    logic [7:0]  op;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic        cep, rstp;
    logic [47:0] p;
    logic        co, ovf;
  } vec_t;
  vec_t tv[20];
  int checks = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic chk_a(input string nm, input logic [47:0] p, input logic co, input logic ovf);
    chk({nm, "_p"}, ia.p, p);
    chk({nm, "_pcout"}, ia.pcout, p);
    chk({nm, "_co"}, 48'(ia.carryout), 48'(co));
    chk({nm, "_cof"}, 48'(ia.carryoutf), 48'(co));
`ifdef POSTADD_OVF_EN
    chk({nm, "_ovf"}, 48'(ia.ovf), 48'(ovf));
`endif
  endtask
  task automatic step_b(input string nm, input logic [7:0] op, input logic [47:0] c,
                        input logic rp, input logic rc, input logic cec, input logic [47:0] exp);
    ib.opmode = op; ib.c = c; rstp_b = rp; rstcy_b = rc; ib.cecarryin = cec;
    @(posedge clk); #1;
    chk(nm, ib.p, exp);
  endtask
  initial begin
    tv[0]  = '{8'h0C, 36'h0, 48'd0, 48'h1234, 48'd0, 1'b1, 1'b0, 48'h1234, 1'b0, 1'b0};
    tv[1]  = '{8'h0C, 36'h0, 48'd0, 48'h5555, 48'd0, 1'b0, 1'b1, 48'h0, 1'b0, 1'b0};
    tv[2]  = '{8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'd5, 1'b0, 1'b0};
    tv[3]  = '{8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'd10, 1'b0, 1'b0};
    tv[4]  = '{8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'd15, 1'b0, 1'b0};
    tv[5]  = '{8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'd20, 1'b0, 1'b0};
    tv[6]  = '{8'h8F, 36'd0, 48'd30, 48'd100, 48'd0, 1'b1, 1'b0, 48'd70, 1'b0, 1'b0};
    tv[7]  = '{8'h8F, 36'd0, 48'd30, 48'd10, 48'd0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFEC, 1'b1, 1'b0};
    tv[8]  = '{8'h2C, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 48'h0, 1'b1, 1'b0};
    tv[9]  = '{8'h0F, 36'd0, 48'd5, 48'd5, 48'd0, 1'b0, 1'b0, 48'h0, 1'b1, 1'b0};
    tv[10] = '{8'h0F, 36'd0, 48'd1, 48'h7FFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1};
    tv[11] = '{8'h0F, 36'd0, 48'd0, 48'h7FFF_FFFF_FFFF, 48'd0, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0};
    tv[12] = '{8'h8F, 36'd0, 48'd1, 48'h8000_0000_0000, 48'd0, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1};
    tv[13] = '{8'h05, 36'hF_FFFF_FFFF, 48'd0, 48'd0, 48'd1, 1'b1, 1'b0, 48'h10_0000_0000, 1'b0, 1'b0};
    tv[14] = '{8'h8D, 36'd1, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0};
    tv[15] = '{8'h5D, 36'd3, 48'd0, 48'd2, 48'd0, 1'b1, 1'b0, 48'd5, 1'b0, 1'b0};
    tv[16] = '{8'h09, 36'd7, 48'd0, 48'd0, 48'd0, 1'b1, 1'b1, 48'd0, 1'b0, 1'b0};
    tv[17] = '{8'h09, 36'd7, 48'd0, 48'd0, 48'd0, 1'b1, 1'b0, 48'd7, 1'b0, 1'b0};
    tv[18] = '{8'h0E, 36'd0, 48'd0, 48'd1, 48'd0, 1'b1, 1'b0, 48'd8, 1'b0, 1'b0};
    tv[19] = '{8'hAF, 36'd0, 48'd3, 48'd10, 48'd0, 1'b1, 1'b0, 48'd6, 1'b0, 1'b0};
    ia.opmode = 8'h00; ia.m = '0; ia.dab = '0; ia.c = '0; ia.pcin = '0;
    ia.carryin = 1'b0; ia.cep = 1'b1; ia.cecarryin = 1'b1;
    ib.opmode = 8'h00; ib.m = '0; ib.dab = '0; ib.c = '0; ib.pcin = '0;
    ib.carryin = 1'b0; ib.cep = 1'b1; ib.cecarryin = 1'b1;
    ic.opmode = 8'h00; ic.m = '0; ic.dab = '0; ic.c = '0; ic.pcin = '0;
    ic.carryin = 1'b0; ic.cep = 1'b1; ic.cecarryin = 1'b1;
    rstp_a = 1'b1; rstcy_a = 1'b1; rstp_b = 1'b1; rstcy_b = 1'b1; rstp_c = 1'b0; rstcy_c = 1'b0;
    ia.opmode = 8'h0C; ia.c = 48'hABCD; ib.opmode = 8'h0C; ib.c = 48'hABCD;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 48'h0, 1'b0, 1'b0);
    chk("reset_b_p", ib.p, 48'h0);
    rstp_a = 1'b0; rstcy_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ia.opmode = tv[i].op; ia.m = tv[i].m; ia.dab = tv[i].dab; ia.c = tv[i].c;
      ia.pcin = tv[i].pcin; ia.cep = tv[i].cep; rstp_a = tv[i].rstp;
      @(posedge clk); #1;
      chk_a($sformatf("v%0d", i), tv[i].p, tv[i].co, tv[i].ovf);
    end
    rstp_b = 1'b0; rstcy_b = 1'b0;
    step_b("cyi_load", 8'h0C, 48'd100, 1'b0, 1'b0, 1'b1, 48'd100);
    step_b("cyi_pulse", 8'h2C, 48'd100, 1'b0, 1'b0, 1'b1, 48'd100);
    step_b("cyi_land", 8'h0C, 48'd100, 1'b0, 1'b0, 1'b1, 48'd101);
    step_b("cyi_after", 8'h0C, 48'd100, 1'b0, 1'b0, 1'b1, 48'd100);
    step_b("rstp_only", 8'h2C, 48'd100, 1'b1, 1'b0, 1'b1, 48'd0);
    step_b("cyi_kept", 8'h0C, 48'd50, 1'b0, 1'b0, 1'b1, 48'd51);
    step_b("rstcy_set", 8'h2C, 48'd0, 1'b0, 1'b0, 1'b1, 48'd0);
    step_b("rstcy_edge", 8'h2C, 48'd0, 1'b0, 1'b1, 1'b1, 48'd1);
    step_b("rstcy_clr", 8'h0C, 48'd0, 1'b0, 1'b0, 1'b1, 48'd0);
    step_b("cecy_hold", 8'h2C, 48'd0, 1'b0, 1'b0, 1'b0, 48'd0);
    step_b("cecy_held", 8'h0C, 48'd0, 1'b0, 1'b0, 1'b1, 48'd0);
    ic.opmode = 8'h0F; ic.c = 48'd5; ic.dab = 48'd6; ic.carryin = 1'b1;
    #1;
    chk("comb_add", ic.p, 48'd12);
    ic.opmode = 8'h2F; ic.carryin = 1'b0;
    #1;
    chk("comb_sel", ic.p, 48'd11);
    rstp_c = 1'b1; ic.cep = 1'b0;
    @(posedge clk); #1;
    chk("comb_rst", ic.p, 48'd11);
    ic.opmode = 8'h8F;
    #1;
    chk("comb_sub_p", ic.pcout, 48'hFFFF_FFFF_FFFF);
    chk("comb_sub_co", 48'(ic.carryoutf), 48'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dsp_post_adder.md
# dsp_post_adder

Post-adder/accumulator stage of the DSP48A1 slice. It sits directly downstream of the multiplier. It combines the multiplier product, the D:A:B concatenation, the C input, the cascade input PCIN and its own registered P into a 48-bit add/subtract result with carry. It drives P, PCOUT and CARRYOUT, and optionally holds the result in the P register for accumulation.

## Interface
- PREG, 1, 1 = P/CARRYOUT registered; 0 = combinational.
- CARRYINREG, 1, 1 = selected carry-in registered (CYI); 0 = combinational.
- CARRYINSEL, "OPMODE5", carry source; "OPMODE5" uses OPMODE[5], "CARRYIN" uses the CARRYIN port.
- CLK  in  1  clock; all registers on rising edge.
- RSTP  in  1  synchronous active-high reset for P, CARRYOUT, OVF.
- RSTCARRYIN  in  1  synchronous active-high reset for the CYI register.
- CEP  in  1  clock enable, P register.
- CECARRYIN  in  1  clock enable, CYI register.
- OPMODE  in  8  bits [1:0] X select, [3:2] Z select, [5] carry, [7] add/sub; bits 4 and 6 are ignored.
- M  in  36  multiplier product, zero-extended to 48.
- DAB  in  48  D[11:0]:A[17:0]:B[17:0] concatenation.
- C  in  48  C operand.
- PCIN  in  48  cascade input from the slice below.
- CARRYIN  in  1  external carry-in.
- P  out  48  result.
- PCOUT  out  48  copy of P for the cascade.
- CARRYOUT  out  1  bit 48 of result.
- CARRYOUTF  out  1  copy of CARRYOUT for fabric.
- OVF  out  1  signed overflow; present only with POSTADD_OVF_EN.

One clock; reset is synchronous and active-high.

## Operation
- X mux, OPMODE[1:0]:
  - 00 → 0
  - 01 → {12'b0, M}
  - 10 → P (register output)
  - 11 → DAB
- Z mux, OPMODE[3:2]:
  - 00 → 0
  - 01 → PCIN
  - 10 → P
  - 11 → C
- CIN source:
  - CARRYINSEL="OPMODE5" → OPMODE[5]; otherwise CARRYIN.
  - Passed through the CYI register when CARRYINREG=1.
- Arithmetic is 49-bit unsigned, computed modulo 2^49:
  - OPMODE[7]=0 → R = Z + X + CIN.
  - OPMODE[7]=1 → R = Z − (X + CIN).
  - P = R[47:0]; CARRYOUT = R[48]. In subtract mode R[48]=1 means borrow.
- PCOUT ≡ P and CARRYOUTF ≡ CARRYOUT at all times.
- X or Z selecting P while PREG=0 is illegal (combinational loop). Behaviour is undefined and the bench must not drive it.
- Register priority, per register: reset > CE hold > load.
  - RSTP clears the register even when CEP=0.
- With PREG=0, RSTP and CEP have no effect on outputs.

## Timing
- Reset values: P=0, PCOUT=0, CARRYOUT=0, CARRYOUTF=0, OVF=0, CYI=0.
- PREG=1: result of inputs at edge n appears on P after edge n. Latency is 1 cycle.
- PREG=0: latency 0.
- CARRYINREG=1: the carry source must be presented one cycle before the data it applies to.
- Accumulate (X or Z = P) uses P as registered at the previous edge. Back-to-back accumulation sustains one new term per cycle.
- Reset mid-accumulation:
  - P is 0 after the reset edge.
  - The next enabled edge accumulates from 0.
  - Inputs presented during the reset cycle are discarded.
- RSTP and RSTCARRYIN are independent. Asserting only RSTP leaves CYI intact.

## Configuration
- POSTADD_OVF_EN defined:
  - OVF port exists.
  - Computed as: the 50-bit sign-extended result of Z ± (X+CIN), with X and Z treated as 48-bit signed, is not representable in 48 bits.
  - Registered alongside P under RSTP/CEP; follows the PREG rules.
- POSTADD_OVF_EN undefined: OVF port and its logic are absent. All other behaviour is identical.

## Structure
- Package dsp_pkg holds:
  - Width constants: P_W=48, M_W=36.
  - OPMODE field localparams: X_ZERO, X_M, X_P, X_DAB, Z_ZERO, Z_PCIN, Z_P, Z_C, OP_ADD, OP_SUB.
  - Carry-select strings.
- Sub-module dsp_pipe_reg:
  - Parameterised width, REG enable, CE, synchronous reset.
  - Instantiated for the P/CARRYOUT/OVF bundle and for CYI.

## Test plan
- Reset: PREG=1, P previously 0x1234, RSTP=1 with CEP=0 for one edge → P=0, CARRYOUT=0.
- Accumulate: OPMODE=8'h09 (X=M, Z=P, add), M=5, CEP=1 for 4 edges from reset → P=5,10,15,20.
- Subtract: OPMODE=8'h8F (X=DAB, Z=C, sub):
  - C=100, DAB=30 → P=70, CARRYOUT=0.
  - C=10, DAB=30 → P=0xFFFFFFFFFFEC, CARRYOUT=1.
- Carry: CARRYINREG=0, OPMODE=8'h2C (X=0, Z=C, OPMODE5=1), C=0xFFFFFFFFFFFF → P=0, CARRYOUT=1.
- CE hold / CYI latency:
  - CEP=0 with changing inputs → P unchanged.
  - CARRYINREG=1, OPMODE5 pulsed for one cycle → +1 lands exactly one result later.
- Overflow (POSTADD_OVF_EN): OPMODE=8'h0F, C=0x7FFFFFFFFFFF, DAB=1 → P=0x800000000000, OVF=1.
  - Next cycle with DAB=0 → OVF=0.
